poly_horner_solver: RTL and testbench

//   Parametrised successor to the fixed quadratic solver. Evaluates a signed

---
 rtl/poly_horner_solver.sv | 152 +++++++++++++++
 tb/tb_poly_horner_solver.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/poly_horner_solver.sv
// poly_horner_solver: evaluates a signed degree-DEG polynomial with Horner's
// method. One shared multiplier alternates MUL/ADD steps under a small FSM.
// Each step either saturates or wraps to RW bits, and a sticky flag records
// any step that left the RW range.
module poly_horner_solver #(
  parameter int DEG = 2,
  parameter int XW  = 8,
  parameter int CW  = 16,
  parameter int RW  = 16,
  parameter int SAT = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [XW-1:0]         x,
  input  logic [(DEG+1)*CW-1:0] coeffs,
  output logic [RW-1:0]         result,
  output logic                  ready,
  output logic                  valid,
  output logic                  overflow
);

  localparam int PW = RW + XW;        // full product width
  localparam int SW = PW + 1;         // product + coefficient sum width
  localparam int IW = $clog2(DEG + 1);

  // Representable RW range, sign-extended to the sum width.
  localparam logic signed [SW-1:0] MAX_V = {{(SW-RW+1){1'b0}}, {(RW-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = {{(SW-RW+1){1'b1}}, {(RW-1){1'b0}}};
  localparam logic [RW-1:0]        RW_MAX = {1'b0, {(RW-1){1'b1}}};
  localparam logic [RW-1:0]        RW_MIN = {1'b1, {(RW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_e;

  state_e                  state_q, state_d;
  logic signed [XW-1:0]    x_q, x_d;
  logic [(DEG+1)*CW-1:0]   c_q, c_d;
  logic signed [RW-1:0]    acc_q, acc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic signed [PW-1:0]    prod_q, prod_d;
  logic                    ovf_q, ovf_d;
  logic [RW-1:0]           result_q, result_d;
  logic                    overflow_q, overflow_d;

  logic signed [CW-1:0]    c_sel;
  logic signed [PW-1:0]    prod_full;
  logic signed [SW-1:0]    sum;
  logic [RW-1:0]           fit_v;
  logic                    step_ovf;

  // State register; reset aborts any evaluation in flight.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE waits for start, MUL/ADD alternate until c_0 is added.
  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = MUL;
      MUL:     state_d = ADD;
      ADD:     if (idx_q == '0) state_d = DONE;
               else             state_d = MUL;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    ready = (state_q == IDLE);
    valid = (state_q == DONE);
  end

  // Arithmetic: coefficient select, shared multiply, sum and range fit.
  always_comb begin
    c_sel = '0;
    for (int i = 0; i < DEG; i++) begin
      if (idx_q == IW'(i)) c_sel = c_q[CW*i +: CW];
    end
    prod_full = PW'(acc_q) * PW'(x_q);
    sum       = SW'(prod_q) + SW'(c_sel);
    step_ovf  = (sum > MAX_V) || (sum < MIN_V);
    fit_v     = sum[RW-1:0];
    if (SAT != 0 && sum > MAX_V) fit_v = RW_MAX;
    if (SAT != 0 && sum < MIN_V) fit_v = RW_MIN;
  end

  // Datapath next values: load on accept, multiply in MUL, accumulate in ADD.
  always_comb begin
    x_d        = x_q;
    c_d        = c_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    prod_d     = prod_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: if (start) begin
        x_d   = x;
        c_d   = coeffs;
        acc_d = RW'(signed'(coeffs[CW*DEG +: CW]));
        idx_d = IW'(DEG - 1);
        ovf_d = 1'b0;
      end
      MUL: prod_d = prod_full;
      ADD: begin
        acc_d = fit_v;
        ovf_d = ovf_q | step_ovf;
        if (idx_q == '0) begin
          result_d   = fit_v;
          overflow_d = ovf_q | step_ovf;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers, including the operand copies, all cleared by reset.
  // NOTE: the coefficient copy is an ordinary flop vector, so it is reset like any other state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_q        <= '0;
      c_q        <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      prod_q     <= '0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      c_q        <= c_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      prod_q     <= prod_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_poly_horner_solver.sv
// Directed bench for poly_horner_solver: a saturating and a wrapping DEG=2
// instance share stimulus; a DEG=4 instance covers throughput with start held.
module tb_poly_horner_solver;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  x     = '0;
  logic [47:0] coeffs = '0;
  logic        start4 = 1'b0;
  logic [79:0] coeffs4 = '0;

  logic [15:0] result_s, result_w, result4;
  logic        ready_s, valid_s, overflow_s;
  logic        ready_w, valid_w, overflow_w;
  logic        ready4, valid4, overflow4;

  int checks = 0;
  int errors = 0;
  int valid_cnt_s = 0;
  int cycle = 0;

  poly_horner_solver #(.DEG(2), .XW(8), .CW(16), .RW(16), .SAT(1)) dut_sat (
    .clock(clock), .reset(reset), .start(start), .x(x), .coeffs(coeffs),
    .result(result_s), .ready(ready_s), .valid(valid_s), .overflow(overflow_s)
  );

  poly_horner_solver #(.DEG(2), .XW(8), .CW(16), .RW(16), .SAT(0)) dut_wrap (
    .clock(clock), .reset(reset), .start(start), .x(x), .coeffs(coeffs),
    .result(result_w), .ready(ready_w), .valid(valid_w), .overflow(overflow_w)
  );

  poly_horner_solver #(.DEG(4), .XW(8), .CW(16), .RW(16), .SAT(1)) dut_deg4 (
    .clock(clock), .reset(reset), .start(start4), .x(x), .coeffs(coeffs4),
    .result(result4), .ready(ready4), .valid(valid4), .overflow(overflow4)
  );

  always #5 clock = ~clock;

  // Free-running cycle count and valid-pulse count of the saturating instance.
  always @(posedge clock) begin
    cycle <= cycle + 1;
    if (valid_s) valid_cnt_s <= valid_cnt_s + 1;
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One DEG=2 evaluation on both instances. With inject set, start is
  // re-asserted with other operands so it is seen at edges 2 and 3 after accept.
  task automatic eval2(input string tag, input logic signed [7:0] xv,
                       input logic signed [15:0] c2, input logic signed [15:0] c1,
                       input logic signed [15:0] c0,
                       input int exp_s, input bit ov_s,
                       input int exp_w, input bit ov_w, input bit inject);
    int k;
    int vs0;
    logic [15:0] prev_s;
    @(posedge clock); #1;
    check({tag, " ready_before"}, ready_s, 1);
    prev_s = result_s;
    vs0    = valid_cnt_s;
    x      = xv;
    coeffs = {c2, c1, c0};
    start  = 1'b1;
    @(posedge clock); #1;               // accept edge
    start  = 1'b0;
    x      = 8'h5A;                     // operands are free to change now
    coeffs = {16'h1234, 16'h4321, 16'h7777};
    k = 0;
    while (!valid_s && k < 20) begin
      if (k == 2) check({tag, " result_stable"}, result_s, prev_s);
      @(posedge clock); #1;
      k++;
      start = inject && (k == 1 || k == 2);
      if (start) begin
        x      = 8'sd7;
        coeffs = {16'sd9, 16'sd9, 16'sd9};
      end
    end
    start = 1'b0;
    // DONE is reached 2*DEG edges after the accept edge (5th edge counting it).
    check({tag, " latency"}, k, 4);
    check({tag, " result_sat"}, $signed(result_s), exp_s);
    check({tag, " ovf_sat"}, overflow_s, ov_s);
    check({tag, " result_wrap"}, $signed(result_w), exp_w);
    check({tag, " ovf_wrap"}, overflow_w, ov_w);
    check({tag, " ready_in_done"}, ready_s, 0);
    @(posedge clock); #1;
    check({tag, " valid_drop"}, valid_s, 0);
    check({tag, " ready_back"}, ready_s, 1);
    check({tag, " valid_pulses"}, valid_cnt_s - vs0, 1);
  endtask

  // Abort an evaluation during the second MUL step with reset.
  task automatic reset_mid_run();
    int vs0;
    @(posedge clock); #1;
    x      = 8'sd5;
    coeffs = {16'sd2, 16'sd3, 16'sd4};
    start  = 1'b1;
    @(posedge clock); #1;               // accept, now MUL step 1
    start = 1'b0;
    @(posedge clock); #1;               // ADD step 1
    @(posedge clock); #1;               // MUL step 2
    vs0   = valid_cnt_s;
    reset = 1'b0;
    #1;
    check("rst_mid ready", ready_s, 1);
    check("rst_mid valid", valid_s, 0);
    check("rst_mid result", result_s, 0);
    check("rst_mid ovf", overflow_s, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("rst_mid no_valid", valid_cnt_s - vs0, 0);
    check("rst_mid idle", ready_s, 1);
  endtask

  // DEG=4 with start held: accepts every 2*DEG+2 = 10 cycles.
  // P(2) = 16 - 16 + 12 - 8 + 5 = 9.
  task automatic deg4_throughput();
    int acc_cyc[$];
    int n;
    x       = 8'sd2;
    coeffs4 = {16'sd1, -16'sd2, 16'sd3, -16'sd4, 16'sd5};
    start4  = 1'b1;
    n = 0;
    while (acc_cyc.size() < 3 && n < 60) begin
      @(negedge clock);
      n++;
      if (ready4 && start4) acc_cyc.push_back(cycle);
      if (valid4) begin
        check("deg4 result", $signed(result4), 9);
        check("deg4 ovf", overflow4, 0);
      end
    end
    start4 = 1'b0;
    check("deg4 accepts", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) begin
      check("deg4 spacing1", acc_cyc[1] - acc_cyc[0], 10);
      check("deg4 spacing2", acc_cyc[2] - acc_cyc[1], 10);
    end
  endtask

  initial begin
    #2;
    check("reset ready", ready_s, 1);
    check("reset valid", valid_s, 0);
    check("reset result", result_s, 0);
    check("reset ovf", overflow_s, 0);
    check("reset ready4", ready4, 1);
    @(posedge clock); #1;
    reset = 1'b1;

    // 2*25 + 3*5 + 4 = 69
    eval2("t1", 8'sd5, 16'sd2, 16'sd3, 16'sd4, 69, 0, 69, 0, 0);
    // 9 + 0 - 10 = -1
    eval2("t2", -8'sd3, 16'sd1, 16'sd0, -16'sd10, -1, 0, -1, 0, 0);
    // stray starts mid-evaluation are ignored
    eval2("t4", 8'sd5, 16'sd2, 16'sd3, 16'sd4, 69, 0, 69, 0, 1);
    // 1000*100 overflows: clamp to 32767, or wrap 100000 -> -31072,
    // then -31072*100 = -3107200 -> low 16 bits = -27008
    eval2("t3", 8'sd100, 16'sd1000, 16'sd0, 16'sd0, 32767, 1, -27008, 1, 0);

    reset_mid_run();
    eval2("t5", 8'sd5, 16'sd2, 16'sd3, 16'sd4, 69, 0, 69, 0, 0);

    deg4_throughput();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
